// File: rtl/uart_pkg.sv
// Shared constants and drain-FSM state encoding for the UART transmit feeder.
package uart_pkg;

  localparam int UART_DATA_W       = 8;
  localparam int UART_BUSY_TIMEOUT = 4;

  localparam logic [1:0] UART_ST_IDLE      = 2'd0;
  localparam logic [1:0] UART_ST_START     = 2'd1;
  localparam logic [1:0] UART_ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] UART_ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = UART_ST_IDLE,
    ST_START     = UART_ST_START,
    ST_WAIT_BUSY = UART_ST_WAIT_BUSY,
    ST_WAIT_DONE = UART_ST_WAIT_DONE
  } drain_state_t;

endpackage

// File: rtl/uart_tx_feeder_byte_fifo.sv
// Parameterised synchronous byte FIFO with registered level/full/empty.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [UART_DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic                   wr_ok;
  logic                   rd_ok;
  logic [AW:0]            level_nxt;

  // A write while full is dropped even if a pop frees a slot on the same edge.
  assign wr_ok   = wr_en && !full;
  assign rd_ok   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_comb begin
    level_nxt = level;
    if (wr_ok && !rd_ok) begin
      level_nxt = level + 1'b1;
    end else if (!wr_ok && rd_ok) begin
      level_nxt = level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == (AW+1)'(DEPTH));
      empty <= (level_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus drain FSM feeding a UART transmitter via tx_start/tx_busy.
// Optional dropped-write reporting (overflow, drop_cnt) with UART_TX_FEEDER_OVF_EN.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   tx_start,
  output logic [UART_DATA_W-1:0] txdata,
  input  logic                   tx_busy,
`ifdef UART_TX_FEEDER_OVF_EN
  output logic                   overflow,
  output logic [7:0]             drop_cnt,
`endif
  output logic [1:0]             state_dbg
);

  localparam int TW = $clog2(UART_BUSY_TIMEOUT);

  drain_state_t           state;
  logic [TW-1:0]          wait_cnt;
  logic [UART_DATA_W-1:0] head;
  logic                   pop;

  // Handshake: a byte moves from the FIFO (valid = !empty) to the transmitter
  // (ready = !tx_busy) only while the drain is IDLE; that edge pops the head
  // into txdata, tx_start marks it for one cycle, and txdata then holds until
  // the next pop, i.e. at least until tx_busy has fallen again.
  assign pop       = (state == ST_IDLE) && !empty && !tx_busy;
  assign state_dbg = state;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (pop),
    .rd_data (head),
    .full    (full),
    .empty   (empty),
    .level   (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      tx_start <= 1'b0;
      txdata   <= '0;
      wait_cnt <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pop) begin
            txdata   <= head;
            tx_start <= 1'b1;
            state    <= ST_START;
          end
        end
        ST_START: begin
          wait_cnt <= '0;
          state    <= ST_WAIT_BUSY;
        end
        // tx_busy is registered in the transmitter, so it lags the start pulse.
        ST_WAIT_BUSY: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (wait_cnt == TW'(UART_BUSY_TIMEOUT - 1)) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef UART_TX_FEEDER_OVF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
      drop_cnt <= 8'h00;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`else
  // Without reporting, a write while full simply vanishes inside the FIFO.
`endif

endmodule
